// File: rtl/me_access_unit.sv
// me_access_unit: memory-access stage between the control unit and the data bus.
// Accepts one request per handshake, runs one word-wide bus transaction with
// byte enables, wait states and a timeout, and returns load data plus an error flag.
// Optional feature macro: ME_MISALIGN_TRAP_EN (trap misaligned half/word accesses).
module me_access_unit #(
  parameter logic [7:0] BUS_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cu_req_valid,
  output logic        cu_req_ready,
  input  logic [31:0] cu_req_addrin,
  input  logic [31:0] cu_req_datain,
  input  logic [2:0]  cu_req_mask,
  input  logic [1:0]  cu_req_req,
  output logic        cu_rsp_valid,
  input  logic        cu_rsp_ready,
  output logic [31:0] cu_rsp_loadeddata,
  output logic        cu_rsp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_BU = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_HU = 3'd3;
  localparam logic [2:0] MT_W  = 3'd4;
  localparam logic [1:0] ME_RD = 2'd0;
  localparam logic [1:0] ME_WR = 2'd1;

  state_t      state_q, state_d;
  logic        busReq_q, busReq_d;
  logic        busWe_q, busWe_d;
  logic [31:0] busAddr_q, busAddr_d;
  logic [3:0]  busBe_q, busBe_d;
  logic [31:0] busWdata_q, busWdata_d;
  logic        rspValid_q, rspValid_d;
  logic [31:0] rspData_q, rspData_d;
  logic        rspErr_q, rspErr_d;
  logic [2:0]  mask_q, mask_d;
  logic [1:0]  offset_q, offset_d;
  logic [7:0]  count_q, count_d;

  logic [3:0]  reqBe;
  logic [31:0] reqWdata;
  logic        reqMisaligned;
  logic        reqIllegalMask;
  logic        reqIsAccess;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic [31:0] loadData;
  logic        timeoutHit;

  // Decode the incoming request into byte enables, replicated store data and error checks.
  always_comb begin
    reqBe          = 4'b1111;
    reqWdata       = cu_req_datain;
    reqMisaligned  = 1'b0;
    reqIllegalMask = (cu_req_mask > MT_W);
    reqIsAccess    = (cu_req_req == ME_RD) || (cu_req_req == ME_WR);
    case (cu_req_mask)
      MT_B, MT_BU: begin
        reqBe    = 4'b0001 << cu_req_addrin[1:0];
        reqWdata = {4{cu_req_datain[7:0]}};
      end
      MT_H, MT_HU: begin
        reqBe    = cu_req_addrin[1] ? 4'b1100 : 4'b0011;
        reqWdata = {2{cu_req_datain[15:0]}};
      end
      default: begin
        reqBe    = 4'b1111;
        reqWdata = cu_req_datain;
      end
    endcase
`ifdef ME_MISALIGN_TRAP_EN
    if (((cu_req_mask == MT_H) || (cu_req_mask == MT_HU)) && cu_req_addrin[0])
      reqMisaligned = 1'b1;
    if ((cu_req_mask == MT_W) && (cu_req_addrin[1:0] != 2'b00))
      reqMisaligned = 1'b1;
`else
    reqMisaligned = 1'b0;
`endif
  end

  // Pick the addressed lane out of the read word and extend it according to the latched mask.
  always_comb begin
    byteLane = bus_rdata[{offset_q, 3'b000} +: 8];
    halfLane = bus_rdata[{offset_q[1], 4'b0000} +: 16];
    case (mask_q)
      MT_B:    loadData = {{24{byteLane[7]}}, byteLane};
      MT_BU:   loadData = {24'd0, byteLane};
      MT_H:    loadData = {{16{halfLane[15]}}, halfLane};
      MT_HU:   loadData = {16'd0, halfLane};
      default: loadData = bus_rdata;
    endcase
    timeoutHit = (BUS_TIMEOUT != 8'd0) &&
                 (({1'b0, count_q} + 9'd1) == {1'b0, BUS_TIMEOUT});
  end

  // Next-state and next-output logic for the IDLE -> BUS -> RESP sequence.
  always_comb begin
    state_d    = state_q;
    busReq_d   = busReq_q;
    busWe_d    = busWe_q;
    busAddr_d  = busAddr_q;
    busBe_d    = busBe_q;
    busWdata_d = busWdata_q;
    rspValid_d = rspValid_q;
    rspData_d  = rspData_q;
    rspErr_d   = rspErr_q;
    mask_d     = mask_q;
    offset_d   = offset_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (cu_req_valid) begin
          mask_d    = cu_req_mask;
          offset_d  = cu_req_addrin[1:0];
          rspData_d = 32'd0;
          rspErr_d  = 1'b0;
          if (!reqIsAccess) begin
            state_d    = S_RESP;
            rspValid_d = 1'b1;
          end else if (reqIllegalMask || reqMisaligned) begin
            state_d    = S_RESP;
            rspValid_d = 1'b1;
            rspErr_d   = 1'b1;
          end else begin
            state_d    = S_BUS;
            busReq_d   = 1'b1;
            busWe_d    = (cu_req_req == ME_WR);
            busAddr_d  = {cu_req_addrin[31:2], 2'b00};
            busBe_d    = reqBe;
            busWdata_d = (cu_req_req == ME_WR) ? reqWdata : 32'd0;
            count_d    = 8'd0;
          end
        end
      end
      S_BUS: begin
        if (bus_ack) begin
          state_d    = S_RESP;
          busReq_d   = 1'b0;
          rspValid_d = 1'b1;
          rspData_d  = busWe_q ? 32'd0 : loadData;
          rspErr_d   = 1'b0;
        end else if (timeoutHit) begin
          state_d    = S_RESP;
          busReq_d   = 1'b0;
          rspValid_d = 1'b1;
          rspData_d  = 32'd0;
          rspErr_d   = 1'b1;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      S_RESP: begin
        if (cu_rsp_ready) begin
          state_d    = S_IDLE;
          rspValid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; synchronous reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busReq_q   <= 1'b0;
      busWe_q    <= 1'b0;
      busAddr_q  <= 32'd0;
      busBe_q    <= 4'd0;
      busWdata_q <= 32'd0;
      rspValid_q <= 1'b0;
      rspData_q  <= 32'd0;
      rspErr_q   <= 1'b0;
      mask_q     <= 3'd0;
      offset_q   <= 2'd0;
      count_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      busReq_q   <= busReq_d;
      busWe_q    <= busWe_d;
      busAddr_q  <= busAddr_d;
      busBe_q    <= busBe_d;
      busWdata_q <= busWdata_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      rspErr_q   <= rspErr_d;
      mask_q     <= mask_d;
      offset_q   <= offset_d;
      count_q    <= count_d;
    end
  end

  assign cu_req_ready      = (state_q == S_IDLE);
  assign cu_rsp_valid      = rspValid_q;
  assign cu_rsp_loadeddata = rspData_q;
  assign cu_rsp_err        = rspErr_q;
  assign bus_req           = busReq_q;
  assign bus_we            = busWe_q;
  assign bus_addr          = busAddr_q;
  assign bus_be            = busBe_q;
  assign bus_wdata         = busWdata_q;

endmodule

// File: tb/tb_me_access_unit.sv
// tb_me_access_unit: directed testbench for me_access_unit (BUS_TIMEOUT = 4).
// Honours ME_MISALIGN_TRAP_EN for the misaligned-word scenario.
module tb_me_access_unit;

  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_BU = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_HU = 3'd3;
  localparam logic [2:0] MT_W  = 3'd4;
  localparam logic [2:0] MT_X  = 3'd5;
  localparam logic [1:0] ME_RD = 2'd0;
  localparam logic [1:0] ME_WR = 2'd1;
  localparam logic [1:0] ME_X  = 2'd2;

  logic        clk;
  logic        rst;
  logic        cu_req_valid;
  logic        cu_req_ready;
  logic [31:0] cu_req_addrin;
  logic [31:0] cu_req_datain;
  logic [2:0]  cu_req_mask;
  logic [1:0]  cu_req_req;
  logic        cu_rsp_valid;
  logic        cu_rsp_ready;
  logic [31:0] cu_rsp_loadeddata;
  logic        cu_rsp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int errors;
  int checks;

  me_access_unit #(.BUS_TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst),
    .cu_req_valid(cu_req_valid), .cu_req_ready(cu_req_ready),
    .cu_req_addrin(cu_req_addrin), .cu_req_datain(cu_req_datain),
    .cu_req_mask(cu_req_mask), .cu_req_req(cu_req_req),
    .cu_rsp_valid(cu_rsp_valid), .cu_rsp_ready(cu_rsp_ready),
    .cu_rsp_loadeddata(cu_rsp_loadeddata), .cu_rsp_err(cu_rsp_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle past it so registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge (accepted there when in IDLE), then withdraw it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [2:0] mask, input logic [1:0] req);
    cu_req_addrin = addr;
    cu_req_datain = data;
    cu_req_mask   = mask;
    cu_req_req    = req;
    cu_req_valid  = 1'b1;
    tick();
    cu_req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (cu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", cu_req_ready); end
    checks++; if (cu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b want 0", cu_rsp_valid); end
    checks++; if (cu_rsp_loadeddata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rsp_data got %h want 0", cu_rsp_loadeddata); end
    checks++; if (cu_rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err got %b want 0", cu_rsp_err); end
    checks++; if ({bus_req, bus_we, bus_be} !== 6'd0) begin errors++; $display("[TB] FAIL reset_bus_ctrl got %b want 0", {bus_req, bus_we, bus_be}); end
    checks++; if ({bus_addr, bus_wdata} !== 64'd0) begin errors++; $display("[TB] FAIL reset_bus_data got %h want 0", {bus_addr, bus_wdata}); end
  endtask

  task automatic test_store_byte();
    applyStimulus(32'h0000_0103, 32'h0000_00A5, MT_B, ME_WR);
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("[TB] FAIL stb_req_we got %b%b want 11", bus_req, bus_we); end
    checks++; if (bus_addr !== 32'h0000_0100) begin errors++; $display("[TB] FAIL stb_addr got %h want 00000100", bus_addr); end
    checks++; if (bus_be !== 4'b1000) begin errors++; $display("[TB] FAIL stb_be got %b want 1000", bus_be); end
    checks++; if (bus_wdata !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL stb_wdata got %h want a5a5a5a5", bus_wdata); end
    checks++; if (cu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL stb_busy_ready got %b want 0", cu_req_ready); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++; if (cu_rsp_valid !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL stb_rsp got valid=%b req=%b want 1 0", cu_rsp_valid, bus_req); end
    checks++; if (cu_rsp_loadeddata !== 32'd0 || cu_rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL stb_rsp_data got %h err=%b want 0 0", cu_rsp_loadeddata, cu_rsp_err); end
    tick();
    checks++; if (cu_rsp_valid !== 1'b0 || cu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL stb_done got valid=%b ready=%b want 0 1", cu_rsp_valid, cu_req_ready); end
  endtask

  // Halfword load at 0x102 with two wait states; response lands three edges after accept.
  task automatic test_load_half();
    logic [2:0]  masks [2];
    logic [31:0] expect_data [2];
    masks[0] = MT_H;  expect_data[0] = 32'hFFFF_8001;
    masks[1] = MT_HU; expect_data[1] = 32'h0000_8001;
    for (int i = 0; i < 2; i++) begin
      bus_rdata = 32'h8001_1234;
      applyStimulus(32'h0000_0102, 32'h0, masks[i], ME_RD);
      checks++; if (bus_addr !== 32'h0000_0100 || bus_be !== 4'b1100 || bus_we !== 1'b0) begin errors++; $display("[TB] FAIL ldh_bus[%0d] got %h %b we=%b want 00000100 1100 0", i, bus_addr, bus_be, bus_we); end
      tick();
      tick();
      checks++; if (cu_rsp_valid !== 1'b0 || bus_req !== 1'b1) begin errors++; $display("[TB] FAIL ldh_wait[%0d] got valid=%b req=%b want 0 1", i, cu_rsp_valid, bus_req); end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      checks++; if (cu_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL ldh_valid[%0d] got %b want 1", i, cu_rsp_valid); end
      checks++; if (cu_rsp_loadeddata !== expect_data[i] || cu_rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL ldh_data[%0d] got %h err=%b want %h 0", i, cu_rsp_loadeddata, cu_rsp_err, expect_data[i]); end
      tick();
    end
  endtask

  // Zero-wait loads covering byte extension and word pass-through.
  task automatic test_load_mix();
    logic [31:0] addrs [4];
    logic [31:0] rdatas [4];
    logic [2:0]  masks [4];
    logic [31:0] expect_data [4];
    addrs[0] = 32'h101; rdatas[0] = 32'h0000_8000; masks[0] = MT_B;  expect_data[0] = 32'hFFFF_FF80;
    addrs[1] = 32'h101; rdatas[1] = 32'h0000_8000; masks[1] = MT_BU; expect_data[1] = 32'h0000_0080;
    addrs[2] = 32'h104; rdatas[2] = 32'hDEAD_BEEF; masks[2] = MT_W;  expect_data[2] = 32'hDEAD_BEEF;
    addrs[3] = 32'h100; rdatas[3] = 32'h1234_F00F; masks[3] = MT_HU; expect_data[3] = 32'h0000_F00F;
    for (int i = 0; i < 4; i++) begin
      bus_rdata = rdatas[i];
      applyStimulus(addrs[i], 32'h0, masks[i], ME_RD);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      checks++; if (cu_rsp_valid !== 1'b1 || cu_rsp_loadeddata !== expect_data[i]) begin errors++; $display("[TB] FAIL ldmix[%0d] got valid=%b data=%h want 1 %h", i, cu_rsp_valid, cu_rsp_loadeddata, expect_data[i]); end
      tick();
    end
  endtask

  task automatic test_misaligned();
    bus_rdata = 32'h1122_3344;
    applyStimulus(32'h0000_0201, 32'h0, MT_W, ME_RD);
`ifdef ME_MISALIGN_TRAP_EN
    checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_busreq got %b want 0", bus_req); end
    checks++; if (cu_rsp_valid !== 1'b1 || cu_rsp_err !== 1'b1 || cu_rsp_loadeddata !== 32'd0) begin errors++; $display("[TB] FAIL mis_rsp got valid=%b err=%b data=%h want 1 1 0", cu_rsp_valid, cu_rsp_err, cu_rsp_loadeddata); end
`else
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0200 || bus_be !== 4'b1111) begin errors++; $display("[TB] FAIL mis_bus got req=%b %h %b want 1 00000200 1111", bus_req, bus_addr, bus_be); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++; if (cu_rsp_valid !== 1'b1 || cu_rsp_err !== 1'b0 || cu_rsp_loadeddata !== 32'h1122_3344) begin errors++; $display("[TB] FAIL mis_rsp got valid=%b err=%b data=%h want 1 0 11223344", cu_rsp_valid, cu_rsp_err, cu_rsp_loadeddata); end
`endif
    tick();
  endtask

  task automatic test_non_bus();
    applyStimulus(32'h0000_0010, 32'hFFFF_FFFF, MT_X, ME_WR);
    checks++; if (bus_req !== 1'b0 || cu_rsp_valid !== 1'b1 || cu_rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_mask got req=%b valid=%b err=%b want 0 1 1", bus_req, cu_rsp_valid, cu_rsp_err); end
    tick();
    applyStimulus(32'h0000_0020, 32'h0, MT_W, ME_X);
    checks++; if (bus_req !== 1'b0 || cu_rsp_valid !== 1'b1 || cu_rsp_err !== 1'b0 || cu_rsp_loadeddata !== 32'd0) begin errors++; $display("[TB] FAIL nop got req=%b valid=%b err=%b data=%h want 0 1 0 0", bus_req, cu_rsp_valid, cu_rsp_err, cu_rsp_loadeddata); end
    tick();
    applyStimulus(32'h0000_0020, 32'h0, MT_W, 2'd3);
    checks++; if (bus_req !== 1'b0 || cu_rsp_valid !== 1'b1 || cu_rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL nop3 got req=%b valid=%b err=%b want 0 1 0", bus_req, cu_rsp_valid, cu_rsp_err); end
    tick();
  endtask

  task automatic test_timeout();
    int highCycles;
    bus_rdata = 32'h5555_AAAA;
    applyStimulus(32'h0000_0300, 32'h0, MT_W, ME_RD);
    highCycles = 0;
    while (bus_req === 1'b1 && highCycles < 20) begin
      highCycles++;
      tick();
    end
    checks++; if (highCycles !== 4) begin errors++; $display("[TB] FAIL timeout_cycles got %0d want 4", highCycles); end
    checks++; if (cu_rsp_valid !== 1'b1 || cu_rsp_err !== 1'b1 || cu_rsp_loadeddata !== 32'd0) begin errors++; $display("[TB] FAIL timeout_rsp got valid=%b err=%b data=%h want 1 1 0", cu_rsp_valid, cu_rsp_err, cu_rsp_loadeddata); end
    tick();
    applyStimulus(32'h0000_0300, 32'h0, MT_W, ME_RD);
    tick();
    tick();
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++; if (cu_rsp_valid !== 1'b1 || cu_rsp_err !== 1'b0 || cu_rsp_loadeddata !== 32'h5555_AAAA) begin errors++; $display("[TB] FAIL ack_wins got valid=%b err=%b data=%h want 1 0 5555aaaa", cu_rsp_valid, cu_rsp_err, cu_rsp_loadeddata); end
    tick();
  endtask

  task automatic test_backpressure();
    cu_rsp_ready = 1'b0;
    bus_rdata = 32'hCAFE_F00D;
    applyStimulus(32'h0000_0500, 32'h0, MT_W, ME_RD);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    bus_rdata = 32'h0BAD_0BAD;
    cu_req_addrin = 32'h0000_0400;
    cu_req_datain = 32'h0000_0077;
    cu_req_mask   = MT_B;
    cu_req_req    = ME_WR;
    cu_req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (cu_rsp_valid !== 1'b1 || cu_rsp_loadeddata !== 32'hCAFE_F00D || cu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold[%0d] got valid=%b data=%h ready=%b want 1 cafef00d 0", i, cu_rsp_valid, cu_rsp_loadeddata, cu_req_ready); end
      tick();
    end
    cu_rsp_ready = 1'b1;
    tick();
    checks++; if (cu_rsp_valid !== 1'b0 || bus_req !== 1'b0 || cu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got valid=%b req=%b ready=%b want 0 0 1", cu_rsp_valid, bus_req, cu_req_ready); end
    tick();
    cu_req_valid = 1'b0;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0400 || bus_wdata !== 32'h7777_7777) begin errors++; $display("[TB] FAIL bp_next got req=%b %h %h want 1 00000400 77777777", bus_req, bus_addr, bus_wdata); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_bus();
    int seenRsp;
    applyStimulus(32'h0000_0600, 32'h0, MT_W, ME_RD);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++; if (bus_req !== 1'b0 || bus_addr !== 32'd0 || bus_be !== 4'd0 || cu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_bus got req=%b %h %b ready=%b want 0 0 0 1", bus_req, bus_addr, bus_be, cu_req_ready); end
    seenRsp = 0;
    for (int i = 0; i < 3; i++) begin
      if (cu_rsp_valid !== 1'b0) seenRsp++;
      tick();
    end
    checks++; if (seenRsp !== 0) begin errors++; $display("[TB] FAIL rstmid_rsp got %0d responses want 0", seenRsp); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    cu_req_valid  = 1'b0;
    cu_req_addrin = 32'd0;
    cu_req_datain = 32'd0;
    cu_req_mask   = 3'd0;
    cu_req_req    = 2'd0;
    cu_rsp_ready  = 1'b1;
    bus_ack       = 1'b0;
    bus_rdata     = 32'd0;
    test_reset();
    test_store_byte();
    test_load_half();
    test_load_mix();
    test_misaligned();
    test_non_bus();
    test_timeout();
    test_backpressure();
    test_reset_mid_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
